mem_unit: RTL

MEM_UNIT -- requirements
Module: mem_unit

---
 rtl/mem_unit.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_unit.sv
// mem_unit: memory stage between EX and WB.
// Stores go to a synchronous BRAM in the accept cycle and retire the following
// cycle. Loads stall upstream for one cycle (LOAD_WAIT) while the BRAM read
// completes, then retire with the selected byte/half/word. Any other instruction
// passes straight through to WB one cycle after it is accepted.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   valid_i .. ram_*    instruction fields from EX; ram_w_data_i and bram_dout
//                       carry address byte 0 in [31:24]; mask bit 3 = byte 0
//   stall_o             upstream holds its instruction while high
//   bram_*              BRAM port (1-cycle synchronous read latency)
//   wb_*                registered writeback outputs
//   misalign_o          only with MEM_MISALIGN_TRAP_EN: pulses with wb_valid for
//                       a load/store whose byte mask is 0000
//
// Build option: define MEM_MISALIGN_TRAP_EN to add the misalignment trap.

module mem_unit #(
    parameter int unsigned MEM_ADDR_WIDTH = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_i,
    input  logic [6:0]                opcode_i,
    input  logic                      rd_we_i,
    input  logic [4:0]                rd_addr_i,
    input  logic [31:0]               rd_data_i,
    input  logic                      ram_we_i,
    input  logic                      ram_re_i,
    input  logic [MEM_ADDR_WIDTH-1:0] ram_wr_addr_i,
    input  logic [31:0]               ram_w_data_i,
    input  logic [3:0]                ram_wr_mask_i,
    input  logic                      ram_r_sign_ext_i,
    output logic                      stall_o,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic                      misalign_o,
`endif
    output logic                      bram_en,
    output logic [3:0]                bram_we,
    output logic [MEM_ADDR_WIDTH-1:0] bram_addr,
    output logic [31:0]               bram_din,
    input  logic [31:0]               bram_dout,
    output logic                      wb_valid,
    output logic [6:0]                wb_opcode,
    output logic                      wb_rd_we,
    output logic [4:0]                wb_rd_addr,
    output logic [31:0]               wb_rd_data
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [0:0] {
        S_IDLE      = 1'b0,
        S_LOAD_WAIT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                wb_valid_q, wb_valid_d;
    logic [6:0]          wb_opcode_q, wb_opcode_d;
    logic                wb_rd_we_q, wb_rd_we_d;
    logic [4:0]          wb_rd_addr_q, wb_rd_addr_d;
    logic [DATA_W-1:0]   wb_rd_data_q, wb_rd_data_d;
    logic [3:0]          ld_mask_q, ld_mask_d;
    logic                ld_sext_q, ld_sext_d;
    logic                ld_rd_we_q, ld_rd_we_d;
    logic [4:0]          ld_rd_addr_q, ld_rd_addr_d;
    logic [6:0]          ld_opcode_q, ld_opcode_d;
`ifdef MEM_MISALIGN_TRAP_EN
    logic                misalign_q, misalign_d;
`endif

    logic accept_c;
    logic store_c;
    logic load_c;

    // Select the addressed lanes from a BRAM word and extend to 32 bits.
    function automatic logic [DATA_W-1:0] load_extract(
        input logic [DATA_W-1:0] dout,
        input logic [3:0]        mask,
        input logic              sext
    );
        logic [HALF_W-1:0] half_v;
        logic [BYTE_W-1:0] byte_v;
        logic              is_half;
        logic              is_byte;
        logic [DATA_W-1:0] res;
        half_v  = '0;
        byte_v  = '0;
        is_half = 1'b0;
        is_byte = 1'b0;
        res     = '0;
        case (mask)
            4'b1111: res = {dout[7:0], dout[15:8], dout[23:16], dout[31:24]};
            4'b1100: begin half_v = {dout[23:16], dout[31:24]}; is_half = 1'b1; end
            4'b0011: begin half_v = {dout[7:0], dout[15:8]};    is_half = 1'b1; end
            4'b1000: begin byte_v = dout[31:24]; is_byte = 1'b1; end
            4'b0100: begin byte_v = dout[23:16]; is_byte = 1'b1; end
            4'b0010: begin byte_v = dout[15:8];  is_byte = 1'b1; end
            4'b0001: begin byte_v = dout[7:0];   is_byte = 1'b1; end
            default: res = '0;
        endcase
        if (is_half) begin
            res = {{HALF_W{sext & half_v[HALF_W-1]}}, half_v};
        end else if (is_byte) begin
            res = {{(DATA_W-BYTE_W){sext & byte_v[BYTE_W-1]}}, byte_v};
        end
        return res;
    endfunction

    // Acceptance decode; a simultaneous read+write request is a store.
    always_comb begin
        accept_c = (state_q == S_IDLE) && valid_i;
        store_c  = accept_c && ram_we_i;
        load_c   = accept_c && ram_re_i && !ram_we_i;
    end

    // BRAM port is driven in the accept cycle only.
    always_comb begin
        bram_en   = 1'b0;
        bram_we   = 4'b0000;
        bram_addr = ram_wr_addr_i;
        bram_din  = ram_w_data_i;
`ifdef MEM_MISALIGN_TRAP_EN
        if (store_c && (ram_wr_mask_i != 4'b0000)) begin
            bram_en = 1'b1;
            bram_we = ram_wr_mask_i;
        end
`else
        if (store_c) begin
            bram_en = 1'b1;
            bram_we = ram_wr_mask_i;
        end
`endif
        if (load_c) begin
            bram_en = 1'b1;
        end
    end

    // Next-state and writeback computation.
    always_comb begin
        state_d      = state_q;
        wb_valid_d   = 1'b0;
        wb_opcode_d  = wb_opcode_q;
        wb_rd_we_d   = wb_rd_we_q;
        wb_rd_addr_d = wb_rd_addr_q;
        wb_rd_data_d = wb_rd_data_q;
        ld_mask_d    = ld_mask_q;
        ld_sext_d    = ld_sext_q;
        ld_rd_we_d   = ld_rd_we_q;
        ld_rd_addr_d = ld_rd_addr_q;
        ld_opcode_d  = ld_opcode_q;
`ifdef MEM_MISALIGN_TRAP_EN
        misalign_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (load_c) begin
                    state_d      = S_LOAD_WAIT;
                    ld_mask_d    = ram_wr_mask_i;
                    ld_sext_d    = ram_r_sign_ext_i;
                    ld_rd_we_d   = rd_we_i;
                    ld_rd_addr_d = rd_addr_i;
                    ld_opcode_d  = opcode_i;
                end else if (store_c) begin
                    wb_valid_d   = 1'b1;
                    wb_opcode_d  = opcode_i;
                    wb_rd_we_d   = 1'b0;
                    wb_rd_addr_d = rd_addr_i;
                    wb_rd_data_d = '0;
`ifdef MEM_MISALIGN_TRAP_EN
                    misalign_d   = (ram_wr_mask_i == 4'b0000);
`endif
                end else if (accept_c) begin
                    wb_valid_d   = 1'b1;
                    wb_opcode_d  = opcode_i;
                    wb_rd_we_d   = rd_we_i;
                    wb_rd_addr_d = rd_addr_i;
                    wb_rd_data_d = rd_data_i;
                end
            end
            S_LOAD_WAIT: begin
                // bram_dout now holds the word addressed in the accept cycle.
                state_d      = S_IDLE;
                wb_valid_d   = 1'b1;
                wb_opcode_d  = ld_opcode_q;
                wb_rd_addr_d = ld_rd_addr_q;
                wb_rd_data_d = load_extract(bram_dout, ld_mask_q, ld_sext_q);
`ifdef MEM_MISALIGN_TRAP_EN
                wb_rd_we_d   = ld_rd_we_q && (ld_mask_q != 4'b0000);
                misalign_d   = (ld_mask_q == 4'b0000);
`else
                wb_rd_we_d   = ld_rd_we_q;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            wb_valid_q   <= 1'b0;
            wb_opcode_q  <= '0;
            wb_rd_we_q   <= 1'b0;
            wb_rd_addr_q <= '0;
            wb_rd_data_q <= '0;
            ld_mask_q    <= '0;
            ld_sext_q    <= 1'b0;
            ld_rd_we_q   <= 1'b0;
            ld_rd_addr_q <= '0;
            ld_opcode_q  <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            wb_valid_q   <= wb_valid_d;
            wb_opcode_q  <= wb_opcode_d;
            wb_rd_we_q   <= wb_rd_we_d;
            wb_rd_addr_q <= wb_rd_addr_d;
            wb_rd_data_q <= wb_rd_data_d;
            ld_mask_q    <= ld_mask_d;
            ld_sext_q    <= ld_sext_d;
            ld_rd_we_q   <= ld_rd_we_d;
            ld_rd_addr_q <= ld_rd_addr_d;
            ld_opcode_q  <= ld_opcode_d;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q   <= misalign_d;
`endif
        end
    end

    // Stall is a pure state decode so no input reaches it combinationally.
    assign stall_o    = (state_q == S_LOAD_WAIT);
    assign wb_valid   = wb_valid_q;
    assign wb_opcode  = wb_opcode_q;
    assign wb_rd_we   = wb_rd_we_q;
    assign wb_rd_addr = wb_rd_addr_q;
    assign wb_rd_data = wb_rd_data_q;
`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign_o = misalign_q;
`endif

endmodule
